// File: rtl/rob_free_list_pkg.sv
// Shared ROB definitions: default sizing, the tag type and the
// pointer-increment-with-wrap helper reused by the ROB and commit logic.
package rob_free_list_pkg;

  localparam int unsigned ROB_NUM_ENTRIES = 8;
  localparam int unsigned ROB_TAG_WIDTH   = $clog2(ROB_NUM_ENTRIES);

  typedef logic [ROB_TAG_WIDTH-1:0] rob_tag_t;

  // Advance a circular pointer by one, wrapping num_entries-1 back to 0.
  // Works for any num_entries >= 2, power of two or not.
  function automatic logic [31:0] ptr_inc_wrap(input logic [31:0] ptr,
                                               input logic [31:0] num_entries);
    logic [31:0] nxt;
    if (ptr == (num_entries - 32'd1)) begin
      nxt = 32'd0;
    end else begin
      nxt = ptr + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/v3_Mem1r1w.sv
// One-read one-write register-file storage. Combinational (zero-latency)
// read, synchronous write. Reset loads slot i with the value i so that a
// free list built on top starts out holding every tag in order.
module v3_Mem1r1w
  import rob_free_list_pkg::*;
#(
  parameter int unsigned p_num_entries = 8,
  parameter int unsigned p_bit_width   = 3,
  parameter int unsigned p_addr_width  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    read_en,
  input  logic [p_addr_width-1:0] read_addr,
  output logic [p_bit_width-1:0]  read_data,
  input  logic                    write_en,
  input  logic [p_addr_width-1:0] write_addr,
  input  logic [p_bit_width-1:0]  write_data
);

  logic [p_bit_width-1:0] mem_q [p_num_entries];
  logic [p_bit_width-1:0] mem_d [p_num_entries];

  // Next-state of the array: copy current contents, overlay the one write.
  always_comb begin
    for (int i = 0; i < int'(p_num_entries); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (write_en) begin
      mem_d[write_addr] = write_data;
    end else begin
      mem_d[write_addr] = mem_q[write_addr];
    end
  end

  // Storage update; reset restores the identity contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(p_num_entries); i++) begin
        mem_q[i] <= p_bit_width'(i);
      end
    end else begin
      for (int i = 0; i < int'(p_num_entries); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read port: data forced to zero when the read is not enabled.
  always_comb begin
    read_data = {p_bit_width{1'b0}};
    if (read_en) begin
      read_data = mem_q[read_addr];
    end else begin
      read_data = {p_bit_width{1'b0}};
    end
  end

endmodule

// File: rtl/rob_free_list.sv
// Circular free-tag queue for ROB allocation. Hands out one tag per cycle at
// the head and accepts returned tags at the tail. Ready signals depend only
// on registered count so the consumer/producer handshakes cannot loop.
module rob_free_list
  import rob_free_list_pkg::*;
#(
  parameter int unsigned p_num_entries = 8,
  parameter int unsigned p_tag_width   = $clog2(p_num_entries)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 alloc_val,
  output logic                                 alloc_rdy,
  output logic [p_tag_width-1:0]               alloc_tag,
  input  logic                                 free_val,
  output logic                                 free_rdy,
  input  logic [p_tag_width-1:0]               free_tag,
  output logic [$clog2(p_num_entries+1)-1:0]   free_count,
  output logic                                 err_overflow
);

  localparam int unsigned p_count_width = $clog2(p_num_entries + 1);

  logic [p_tag_width-1:0]   head_q, head_d;
  logic [p_tag_width-1:0]   tail_q, tail_d;
  logic [p_count_width-1:0] count_q, count_d;
  logic                     err_q, err_d;
  logic                     alloc_fire;
  logic                     free_fire;
  logic                     mem_write_en;

  // Handshakes and next-state of the head/tail/count/error registers.
  always_comb begin
    alloc_rdy  = (count_q != {p_count_width{1'b0}});
    free_rdy   = (count_q != p_count_width'(p_num_entries));
    alloc_fire = alloc_val & alloc_rdy;
    free_fire  = free_val & free_rdy;

    head_d = head_q;
    if (alloc_fire) begin
      head_d = p_tag_width'(ptr_inc_wrap(32'(head_q), 32'(p_num_entries)));
    end else begin
      head_d = head_q;
    end

    tail_d = tail_q;
    if (free_fire) begin
      tail_d = p_tag_width'(ptr_inc_wrap(32'(tail_q), 32'(p_num_entries)));
    end else begin
      tail_d = tail_q;
    end

    count_d = count_q;
    case ({alloc_fire, free_fire})
      2'b10:   count_d = count_q - p_count_width'(1);
      2'b01:   count_d = count_q + p_count_width'(1);
      default: count_d = count_q;
    endcase

    // A return attempt while full is a caller bug; remember it until reset.
    err_d = err_q | (free_val & ~free_rdy);
  end

  // Control registers; reset restores a full list with pointers at slot 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= {p_tag_width{1'b0}};
      tail_q  <= {p_tag_width{1'b0}};
      count_q <= p_count_width'(p_num_entries);
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign mem_write_en = free_fire & ~reset;
  assign free_count   = count_q;
  assign err_overflow = err_q;

  v3_Mem1r1w #(
    .p_num_entries (p_num_entries),
    .p_bit_width   (p_tag_width),
    .p_addr_width  (p_tag_width)
  ) u_storage (
    .clk        (clk),
    .reset      (reset),
    .read_en    (alloc_rdy),
    .read_addr  (head_q),
    .read_data  (alloc_tag),
    .write_en   (mem_write_en),
    .write_addr (tail_q),
    .write_data (free_tag)
  );

endmodule

// File: tb/tb_rob_free_list.sv
// Bench for rob_free_list: a directed vector table for the documented
// scenarios, then randomized traffic against a queue-based reference model,
// then a mid-operation reset followed by a drain.
module tb_rob_free_list;
  import rob_free_list_pkg::*;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_val;
  logic       alloc_rdy;
  rob_tag_t   alloc_tag;
  logic       free_val;
  logic       free_rdy;
  rob_tag_t   free_tag;
  logic [3:0] free_count;
  logic       err_overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: the list of held tags in allocation order.
  int q[$];
  bit m_err;

  typedef struct {
    logic       rst;
    logic       av;
    logic       fv;
    logic [2:0] ft;
    logic       e_rdy;
    logic [2:0] e_tag;
    logic       e_frdy;
    logic [3:0] e_cnt;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  rob_free_list #(.p_num_entries(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_val    (alloc_val),
    .alloc_rdy    (alloc_rdy),
    .alloc_tag    (alloc_tag),
    .free_val     (free_val),
    .free_rdy     (free_rdy),
    .free_tag     (free_tag),
    .free_count   (free_count),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic av, input logic fv, input int ft,
                     input logic rdy, input int tag, input logic frdy,
                     input int cnt, input logic err);
    vec_t v;
    v.rst = r; v.av = av; v.fv = fv; v.ft = 3'(ft);
    v.e_rdy = rdy; v.e_tag = 3'(tag); v.e_frdy = frdy;
    v.e_cnt = 4'(cnt); v.e_err = err;
    tbl.push_back(v);
  endtask

  // Drive inputs on the falling edge; outputs are then stable for sampling.
  task automatic drive(input logic r, input logic av, input logic fv, input int ft);
    @(negedge clk);
    reset = r; alloc_val = av; free_val = fv; free_tag = 3'(ft);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < N; i++) q.push_back(i);
    m_err = 1'b0;
  endtask

  // Compare current outputs with the model's view of the held-tag list.
  task automatic check_model(input string ctx);
    int sz;
    sz = q.size();
    chk({ctx, " alloc_rdy"}, int'(alloc_rdy), (sz != 0) ? 1 : 0);
    chk({ctx, " alloc_tag"}, int'(alloc_tag), (sz != 0) ? q[0] : 0);
    chk({ctx, " free_rdy"}, int'(free_rdy), (sz != N) ? 1 : 0);
    chk({ctx, " free_count"}, int'(free_count), sz);
    chk({ctx, " err_overflow"}, int'(err_overflow), int'(m_err));
  endtask

  // Advance one clock and apply the handshake rules to the model.
  task automatic step_model(input logic r, input logic av, input logic fv, input int ft);
    bit afire, ffire;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      afire = av && (q.size() > 0);
      ffire = fv && (q.size() < N);
      if (fv && q.size() == N) m_err = 1'b1;
      if (afire) void'(q.pop_front());
      if (ffire) q.push_back(ft);
    end
  endtask

  initial begin
    int ra, rf, rt;
    reset = 1'b1; alloc_val = 1'b0; free_val = 1'b0; free_tag = '0;
    repeat (2) @(posedge clk);

    // Directed scenarios: drain, free-after-drain, empty+free, simultaneous,
    // reset overriding fires, overflow with unchanged contents.
    add(1, 0, 0, 0,  1, 0, 0, 8, 0);
    for (int i = 0; i < N; i++) add(0, 1, 0, 0,  1, i, (i != 0), N - i, 0);
    add(0, 0, 1, 5,  0, 0, 1, 0, 0);
    add(0, 0, 1, 2,  1, 5, 1, 1, 0);
    add(0, 1, 0, 0,  1, 5, 1, 2, 0);
    add(0, 1, 0, 0,  1, 2, 1, 1, 0);
    add(0, 1, 1, 4,  0, 0, 1, 0, 0);
    add(0, 0, 1, 1,  1, 4, 1, 1, 0);
    add(0, 0, 1, 7,  1, 4, 1, 2, 0);
    add(0, 1, 1, 6,  1, 4, 1, 3, 0);
    add(0, 1, 0, 0,  1, 1, 1, 3, 0);
    add(0, 1, 0, 0,  1, 7, 1, 2, 0);
    add(0, 1, 0, 0,  1, 6, 1, 1, 0);
    add(0, 0, 0, 0,  0, 0, 1, 0, 0);
    add(1, 1, 1, 3,  0, 0, 1, 0, 0);
    add(0, 0, 1, 3,  1, 0, 0, 8, 0);
    add(0, 0, 0, 0,  1, 0, 0, 8, 1);
    for (int i = 0; i < N; i++) add(0, 1, 0, 0,  1, i, (i != 0), N - i, 1);
    add(0, 0, 0, 0,  0, 0, 1, 0, 1);

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].av, tbl[k].fv, int'(tbl[k].ft));
      chk($sformatf("vec%0d alloc_rdy", k), int'(alloc_rdy), int'(tbl[k].e_rdy));
      chk($sformatf("vec%0d alloc_tag", k), int'(alloc_tag), int'(tbl[k].e_tag));
      chk($sformatf("vec%0d free_rdy", k), int'(free_rdy), int'(tbl[k].e_frdy));
      chk($sformatf("vec%0d free_count", k), int'(free_count), int'(tbl[k].e_cnt));
      chk($sformatf("vec%0d err_overflow", k), int'(err_overflow), int'(tbl[k].e_err));
      @(posedge clk);
    end

    // Re-synchronise with the model via reset, then random traffic.
    drive(1, 0, 0, 0);
    step_model(1, 0, 0, 0);
    for (int c = 0; c < 300; c++) begin
      ra = ($urandom_range(0, 99) < 55) ? 1 : 0;
      rf = ($urandom_range(0, 99) < 50) ? 1 : 0;
      rt = int'($urandom_range(0, N - 1));
      drive(1'b0, ra[0], rf[0], rt);
      check_model($sformatf("rnd%0d", c));
      step_model(1'b0, ra[0], rf[0], rt);
    end

    // Partially drained, with pending returns: reset mid-operation.
    for (int c = 0; c < 5; c++) begin
      drive(0, 1, (c == 2), 6);
      check_model($sformatf("pre%0d", c));
      step_model(0, 1, (c == 2), 6);
    end
    drive(1, 1, 1, 5);
    step_model(1, 1, 1, 5);
    for (int c = 0; c < N + 1; c++) begin
      drive(0, 1, 0, 0);
      check_model($sformatf("post%0d", c));
      step_model(0, 1, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
